// File: rtl/ysyx_22050039_ifu.sv
// rtl/ysyx_22050039_ifu.sv - RV64 instruction fetch stage: PC, single-outstanding imem fetch, instruction FIFO to decode.
// Optional IFU_MISALIGN_CHECK_EN: misaligned redirect raises sticky fetch_fault and stops fetching.
module ysyx_22050039_ifu #(
  parameter int              XLEN       = 64,
  parameter int              INST_LEN   = 32,
  parameter logic [XLEN-1:0] RESET_PC   = 64'h8000_0000,
  parameter int              FIFO_DEPTH = 2
) (
  input  logic                clk,
  input  logic                rst,
  output logic                imem_req_valid,
  input  logic                imem_req_ready,
  output logic [XLEN-1:0]     imem_req_addr,
  input  logic                imem_resp_valid,
  input  logic [INST_LEN-1:0] imem_resp_data,
  output logic                inst_valid,
  input  logic                inst_ready,
  output logic [INST_LEN-1:0] inst,
  output logic [XLEN-1:0]     inst_pc,
  input  logic                redirect,
  input  logic [XLEN-1:0]     redirect_pc,
  output logic                fetch_fault
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_DROP} state_e;

  state_e              state_q, state_d;
  logic [XLEN-1:0]     pc_q, pc_d;
  logic [XLEN-1:0]     req_pc_q;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [INST_LEN-1:0] buf_inst_q [FIFO_DEPTH];
  logic [XLEN-1:0]     buf_pc_q   [FIFO_DEPTH];
  logic [INST_LEN-1:0] inst_q, inst_d;
  logic [XLEN-1:0]     inst_pc_q, inst_pc_d;

  logic [XLEN-1:0]     target;
  logic                req_block;
  logic                accept;
  logic                push;
  logic                pop;

`ifdef IFU_MISALIGN_CHECK_EN
  logic fault_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fault_q <= 1'b0;
    end else begin
      fault_q <= fault_q | (redirect & (|redirect_pc[1:0]));
    end
  end

  assign target      = redirect_pc;
  assign req_block   = fault_q;
  assign fetch_fault = fault_q;
`else
  assign target      = {redirect_pc[XLEN-1:2], redirect_pc[1:0] & 2'b00};
  assign req_block   = 1'b0;
  assign fetch_fault = 1'b0;
`endif

  // The space check alone covers the in-flight slot: nothing is pushed while in REQ.
  assign imem_req_valid = rst & (state_q == S_REQ) & (cnt_q < CNT_W'(FIFO_DEPTH)) & ~req_block;
  assign imem_req_addr  = pc_q;
  assign accept         = imem_req_valid & imem_req_ready;
  assign push           = (state_q == S_WAIT) & imem_resp_valid & ~redirect;
  assign inst_valid     = (cnt_q != '0);
  assign pop            = inst_valid & inst_ready & ~redirect;
  assign inst           = inst_q;
  assign inst_pc        = inst_pc_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_REQ:  if (accept) state_d = redirect ? S_DROP : S_WAIT;
      S_WAIT: begin
        if (imem_resp_valid) state_d = S_REQ;
        else if (redirect)   state_d = S_DROP;
      end
      S_DROP: if (imem_resp_valid) state_d = S_REQ;
      default: state_d = S_REQ;
    endcase
  end

  always_comb begin
    pc_d     = pc_q;
    cnt_d    = cnt_q + CNT_W'(push) - CNT_W'(pop);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    wr_ptr_d = wr_ptr_q + PTR_W'(push);
    if (accept) pc_d = pc_q + XLEN'(4);
    if (redirect) begin
      pc_d     = target;
      cnt_d    = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
    end
  end

  // Head registers only move when something remains, so an empty FIFO keeps the last value.
  always_comb begin
    inst_d    = inst_q;
    inst_pc_d = inst_pc_q;
    if (cnt_d != '0) begin
      if (push && (rd_ptr_d == wr_ptr_q)) begin
        inst_d    = imem_resp_data;
        inst_pc_d = req_pc_q;
      end else begin
        inst_d    = buf_inst_q[rd_ptr_d];
        inst_pc_d = buf_pc_q[rd_ptr_d];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_REQ;
      pc_q      <= RESET_PC;
      req_pc_q  <= '0;
      cnt_q     <= '0;
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      inst_q    <= '0;
      inst_pc_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      cnt_q     <= cnt_d;
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      inst_q    <= inst_d;
      inst_pc_q <= inst_pc_d;
      if (accept) req_pc_q <= pc_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        buf_inst_q[i] <= '0;
        buf_pc_q[i]   <= '0;
      end
    end else if (push) begin
      buf_inst_q[wr_ptr_q] <= imem_resp_data;
      buf_pc_q[wr_ptr_q]   <= req_pc_q;
    end
  end

endmodule

// File: tb/tb_ysyx_22050039_ifu.sv
// tb/tb_ysyx_22050039_ifu.sv - scoreboard bench for ysyx_22050039_ifu with a behavioural memory and program-order model.
module tb_ysyx_22050039_ifu;

  localparam logic [63:0] RESET_PC = 64'h8000_0000;

  logic        clk;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [63:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [63:0] inst_pc;
  logic        redirect;
  logic [63:0] redirect_pc;
  logic        fetch_fault;

  ysyx_22050039_ifu dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst), .inst_pc(inst_pc),
    .redirect(redirect), .redirect_pc(redirect_pc), .fetch_fault(fetch_fault)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [63:0] pc;
    logic [31:0] ins;
  } exp_t;

  int          total = 0;
  int          bad = 0;
  int          deliveries = 0;
  exp_t        exp_q[$];
  logic [63:0] req_log[$];
  logic [63:0] exp_nx = RESET_PC;
  bit          mem_pend = 0;
  int          mem_cnt = 0;
  logic [63:0] mem_addr = '0;
  int          lat_min = 1;
  int          lat_max = 1;
  bit          rdy_rand = 0;
  bit          prev_hold = 0;
  logic [31:0] prev_inst;
  logic [63:0] prev_pc;
  int          n;
  int          d0;

  function automatic logic [31:0] mem_fn(input logic [63:0] a);
    return a[31:0] ^ a[63:32] ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  // Memory drives just after the rising edge; the scoreboard samples just before the next one.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      imem_resp_valid = 1'b0;
      if (rst && mem_pend) begin
        if (mem_cnt == 0) begin
          imem_resp_valid = 1'b1;
          imem_resp_data  = mem_fn(mem_addr);
          mem_pend        = 0;
        end else begin
          mem_cnt--;
        end
      end
      imem_req_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      #7;
      if (!rst) begin
        mem_pend  = 0;
        prev_hold = 0;
        exp_q.delete();
        req_log.delete();
        exp_nx = RESET_PC;
      end else begin
        chk("fetch_fault", {63'd0, fetch_fault}, 64'd0);
        if (prev_hold) begin
          chk("hold_valid", {63'd0, inst_valid}, 64'd1);
          chk("hold_inst", {32'd0, inst}, {32'd0, prev_inst});
          chk("hold_pc", inst_pc, prev_pc);
        end
        if (redirect) begin
          exp_q.delete();
          exp_nx = {redirect_pc[63:2], 2'b00};
        end else if (inst_valid && inst_ready) begin
          e = exp_q.pop_front();
          chk("inst_pc", inst_pc, e.pc);
          chk("inst", {32'd0, inst}, {32'd0, e.ins});
          deliveries++;
        end
        if (imem_req_valid && imem_req_ready) begin
          chk("one_outstanding", {63'd0, mem_pend}, 64'd0);
          mem_pend = 1;
          mem_addr = imem_req_addr;
          mem_cnt  = $urandom_range(lat_min - 1, lat_max - 1);
          req_log.push_back(imem_req_addr);
        end
        prev_hold = inst_valid && !inst_ready && !redirect;
        prev_inst = inst;
        prev_pc   = inst_pc;
        while (exp_q.size() < 8) begin
          e.pc  = exp_nx;
          e.ins = mem_fn(exp_nx);
          exp_q.push_back(e);
          exp_nx = exp_nx + 64'd4;
        end
      end
    end
  end

  task automatic wait_log(input int target);
    int k = 0;
    while (req_log.size() < target && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk("req_timeout", {63'd0, req_log.size() >= target}, 64'd1);
  endtask

  task automatic wait_resp();
    int k = 0;
    @(negedge clk);
    while (!imem_resp_valid && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("resp_timeout", {63'd0, imem_resp_valid}, 64'd1);
  endtask

  task automatic pulse_redirect(input logic [63:0] t);
    #1;
    redirect    = 1'b1;
    redirect_pc = t;
    @(posedge clk);
    #1;
    redirect = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0; inst_ready = 1'b0; redirect = 1'b0; redirect_pc = '0;
    imem_req_ready = 1'b0; imem_resp_valid = 1'b0; imem_resp_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req_valid", {63'd0, imem_req_valid}, 64'd0);
    chk("rst_inst_valid", {63'd0, inst_valid}, 64'd0);
    chk("rst_inst", {32'd0, inst}, 64'd0);
    chk("rst_inst_pc", inst_pc, 64'd0);
    chk("rst_fault", {63'd0, fetch_fault}, 64'd0);

    // Sequential fetch with 1-cycle memory
    inst_ready = 1'b1;
    @(posedge clk);
    #1 rst = 1'b1;
    wait_resp();
    chk("t1_empty_at_resp", {63'd0, inst_valid}, 64'd0);
    @(negedge clk);
    chk("t1_valid_next", {63'd0, inst_valid}, 64'd1);
    chk("t1_first_pc", inst_pc, RESET_PC);
    repeat (10) @(negedge clk);
    chk("t1_addr0", req_log[0], 64'h8000_0000);
    chk("t1_addr1", req_log[1], 64'h8000_0004);
    chk("t1_addr2", req_log[2], 64'h8000_0008);

    // Decode stalls: FIFO fills to two entries and fetch stops
    inst_ready = 1'b0;
    do_reset();
    repeat (10) @(negedge clk);
    chk("t2_nreq", req_log.size(), 64'd2);
    chk("t2_req_valid", {63'd0, imem_req_valid}, 64'd0);
    chk("t2_head_pc", inst_pc, RESET_PC);
    chk("t2_head_inst", {32'd0, inst}, {32'd0, mem_fn(RESET_PC)});
    @(posedge clk);
    #1 inst_ready = 1'b1;
    wait_log(3);
    chk("t2_resume", req_log[2], 64'h8000_0008);

    // Redirect while waiting on a slow response
    lat_min = 3; lat_max = 3;
    do_reset();
    wait_log(3);
    n = req_log.size();
    pulse_redirect(64'h8000_0100);
    @(negedge clk);
    chk("t3_flush", {63'd0, inst_valid}, 64'd0);
    wait_log(n + 1);
    chk("t3_next_req", req_log[n], 64'h8000_0100);

    // Redirect coincident with request accept, then with a response
    lat_min = 1; lat_max = 1;
    do_reset();
    n = 0;
    while (!(imem_req_valid && imem_req_addr == 64'h8000_0010) && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("t4_reach_10", imem_req_addr, 64'h8000_0010);
    n = req_log.size();
    pulse_redirect(64'h8000_0200);
    wait_log(n + 2);
    chk("t4a_accepted", req_log[n], 64'h8000_0010);
    chk("t4a_next_req", req_log[n + 1], 64'h8000_0200);
    wait_resp();
    n = req_log.size();
    pulse_redirect(64'h8000_0300);
    wait_log(n + 1);
    chk("t4b_next_req", req_log[n], 64'h8000_0300);
    n = 0;
    while (!inst_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("t4b_first_pc", inst_pc, 64'h8000_0300);

    // PC wrap-around at the top of the address space
    wait_resp();
    n = req_log.size();
    pulse_redirect(64'hFFFF_FFFF_FFFF_FFFC);
    wait_log(n + 2);
    chk("t5_top", req_log[n], 64'hFFFF_FFFF_FFFF_FFFC);
    chk("t5_wrap", req_log[n + 1], 64'h0);

    // Misaligned target is aligned down when the check is not built in
    wait_resp();
    n = req_log.size();
    pulse_redirect(64'h8000_0102);
    wait_log(n + 1);
    chk("t6_aligned_req", req_log[n], 64'h8000_0100);
    chk("t6_no_fault", {63'd0, fetch_fault}, 64'd0);

    // Random traffic, random redirects, one mid-run reset
    rdy_rand = 1; lat_min = 1; lat_max = 4;
    d0 = deliveries;
    for (int c = 0; c < 800; c++) begin
      @(posedge clk);
      #1;
      inst_ready  = ($urandom_range(0, 3) != 0);
      redirect    = ($urandom_range(0, 24) == 0);
      redirect_pc = ($urandom_range(0, 3) == 0) ? (64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(0, 15)))
                                                : {32'($urandom), 32'($urandom)};
      rst = (c != 400);
    end
    @(posedge clk);
    #1 redirect = 1'b0; inst_ready = 1'b1; rst = 1'b1;
    repeat (30) @(negedge clk);
    chk("rand_progress", {63'd0, deliveries > d0 + 50}, 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
